// File: rtl/dm_hart_ctl_pkg.sv
// Shared debug-module definitions: hart run-control states and the
// dmcontrol/dmstatus bit positions used by the DMI register file.
package dm_hart_ctl_pkg;

  typedef enum logic [1:0] {
    DM_HC_RUN      = 2'd0,
    DM_HC_HALTED   = 2'd1,
    DM_HC_RES_PEND = 2'd2
  } dm_hc_state_e;

  localparam int unsigned DMCONTROL_HALTREQ      = 31;
  localparam int unsigned DMCONTROL_RESUMEREQ    = 30;
  localparam int unsigned DMCONTROL_ACKHAVERESET = 28;
  localparam int unsigned DMCONTROL_DMACTIVE     = 0;

  localparam int unsigned DMSTATUS_ALLHAVERESET = 19;
  localparam int unsigned DMSTATUS_ANYHAVERESET = 18;
  localparam int unsigned DMSTATUS_ALLRESUMEACK = 17;
  localparam int unsigned DMSTATUS_ANYRESUMEACK = 16;
  localparam int unsigned DMSTATUS_ALLRUNNING   = 11;
  localparam int unsigned DMSTATUS_ANYRUNNING   = 10;
  localparam int unsigned DMSTATUS_ALLHALTED    = 9;
  localparam int unsigned DMSTATUS_ANYHALTED    = 8;

endpackage

// File: rtl/dm_hart_ctl.sv
// Debug-module side of the single-hart halt/resume handshake: turns dmcontrol
// writes into halt/resume request levels and tracks dmstatus run-state bits.
module dm_hart_ctl
  import dm_hart_ctl_pkg::*;
#(
  parameter int RESUME_TIMEOUT = 1024,
  parameter int CNT_W          = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dmactive,
  input  logic ctl_we,
  input  logic ctl_haltreq,
  input  logic ctl_resumereq,
  input  logic ctl_ackhavereset,
  input  logic hart_halted,
  input  logic hart_reset,
  output logic halt_req,
  output logic resume_req,
  output logic haltreq_q,
  output logic st_halted,
  output logic st_running,
  output logic st_resumeack,
  output logic st_havereset,
  output logic resume_err
);

  // Abort fires on the cycle the count of pending cycles reaches the limit.
  localparam bit               TIMEOUT_EN = (RESUME_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST   = TIMEOUT_EN ? CNT_W'(RESUME_TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  dm_hc_state_e     state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             haltreq_next;
  logic             resumeack_next;
  logic             err_next;
  logic             havereset_next;
  logic             resume_wr;

  assign resume_wr = ctl_we && ctl_resumereq && !ctl_haltreq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= DM_HC_RUN;
    end else if (!dmactive) begin
      state_reg <= DM_HC_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    haltreq_next   = haltreq_q;
    resumeack_next = st_resumeack;
    err_next       = resume_err;
    havereset_next = st_havereset;

    if (ctl_we) begin
      haltreq_next = ctl_haltreq;
    end
    if (ctl_we && ctl_ackhavereset) begin
      havereset_next = 1'b0;
    end

    // A hart reset overrides everything, including a same-cycle ack.
    if (hart_reset) begin
      state_next     = DM_HC_RUN;
      cnt_next       = '0;
      havereset_next = 1'b1;
    end else begin
      case (state_reg)
        DM_HC_RUN: begin
          if (hart_halted) begin
            state_next = DM_HC_HALTED;
          end
        end
        DM_HC_HALTED: begin
          if (resume_wr) begin
            state_next     = DM_HC_RES_PEND;
            cnt_next       = '0;
            resumeack_next = 1'b0;
            err_next       = 1'b0;
          end
        end
        DM_HC_RES_PEND: begin
          // Completion takes priority over the timeout on the same cycle.
          if (!hart_halted) begin
            state_next     = DM_HC_RUN;
            cnt_next       = '0;
            resumeack_next = 1'b1;
          end else if (TIMEOUT_EN && (cnt_reg >= CNT_LAST)) begin
            state_next = DM_HC_HALTED;
            cnt_next   = '0;
            err_next   = 1'b1;
          end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_next = DM_HC_RUN;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg      <= '0;
      haltreq_q    <= 1'b0;
      halt_req     <= 1'b0;
      resume_req   <= 1'b0;
      st_halted    <= 1'b0;
      st_running   <= 1'b1;
      st_resumeack <= 1'b0;
      st_havereset <= 1'b1;
      resume_err   <= 1'b0;
    end else if (!dmactive) begin
      cnt_reg      <= '0;
      haltreq_q    <= 1'b0;
      halt_req     <= 1'b0;
      resume_req   <= 1'b0;
      st_halted    <= 1'b0;
      st_running   <= 1'b1;
      st_resumeack <= 1'b0;
      st_havereset <= 1'b1;
      resume_err   <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      haltreq_q    <= haltreq_next;
      halt_req     <= haltreq_next && !hart_reset && (state_next != DM_HC_RES_PEND);
      resume_req   <= (state_next == DM_HC_RES_PEND);
      st_halted    <= (state_next == DM_HC_HALTED);
      st_running   <= (state_next == DM_HC_RUN) && !hart_reset;
      st_resumeack <= resumeack_next;
      st_havereset <= havereset_next;
      resume_err   <= err_next;
    end
  end

endmodule

// File: tb/tb_dm_hart_ctl.sv
// Directed bench for dm_hart_ctl: expected output vectors are queued as each
// stimulus step is driven and compared once the clock edge has produced them.
module tb_dm_hart_ctl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dmactive = 1'b1;
  logic ctl_we = 1'b0;
  logic ctl_haltreq = 1'b0;
  logic ctl_resumereq = 1'b0;
  logic ctl_ackhavereset = 1'b0;
  logic hart_halted = 1'b0;
  logic hart_reset = 1'b0;
  logic halt_req, resume_req, haltreq_q, st_halted, st_running;
  logic st_resumeack, st_havereset, resume_err;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;
  exp_t sb[$];

  logic [7:0] out_vec;
  assign out_vec = {halt_req, resume_req, haltreq_q, st_halted,
                    st_running, st_resumeack, st_havereset, resume_err};

  dm_hart_ctl #(
    .RESUME_TIMEOUT(8),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .dmactive(dmactive),
    .ctl_we(ctl_we),
    .ctl_haltreq(ctl_haltreq),
    .ctl_resumereq(ctl_resumereq),
    .ctl_ackhavereset(ctl_ackhavereset),
    .hart_halted(hart_halted),
    .hart_reset(hart_reset),
    .halt_req(halt_req),
    .resume_req(resume_req),
    .haltreq_q(haltreq_q),
    .st_halted(st_halted),
    .st_running(st_running),
    .st_resumeack(st_resumeack),
    .st_havereset(st_havereset),
    .resume_err(resume_err)
  );

  always #5 clk = ~clk;

  // Vector order: halt_req resume_req haltreq_q st_halted st_running
  //               st_resumeack st_havereset resume_err
  function automatic logic [7:0] v(input logic hr, input logic rr, input logic hq,
                                   input logic sh, input logic sr, input logic ra,
                                   input logic hv, input logic re);
    return {hr, rr, hq, sh, sr, ra, hv, re};
  endfunction

  task automatic expect_vec(input string tag, input logic [7:0] e);
    sb.push_back('{tag, e});
  endtask

  task automatic compare_front();
    exp_t item;
    if (sb.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_empty observed=%b required=an entry", out_vec);
    end else begin
      item = sb.pop_front();
      tests_run++;
      assert (out_vec === item.exp) else begin
        tests_failed++;
        $error("FAIL %s observed=%b expected=%b", item.tag, out_vec, item.exp);
      end
      $display("[TB] %-16s out=%b exp=%b", item.tag, out_vec, item.exp);
    end
  endtask

  task automatic cyc_check();
    @(posedge clk);
    #1;
    compare_front();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic hq, input logic rq, input logic ack);
    ctl_we = 1'b1;
    ctl_haltreq = hq;
    ctl_resumereq = rq;
    ctl_ackhavereset = ack;
  endtask

  task automatic wr_end();
    ctl_we = 1'b0;
    ctl_haltreq = 1'b0;
    ctl_resumereq = 1'b0;
    ctl_ackhavereset = 1'b0;
  endtask

  initial begin
    // Reset state
    expect_vec("reset", v(0,0,0,0,1,0,1,0));
    cyc_check();
    idle_cycles(1);
    rst_n = 1'b1;
    expect_vec("reset_release", v(0,0,0,0,1,0,1,0));
    cyc_check();

    // 1: halt request, hart halts three cycles later
    wr(1, 0, 0);
    expect_vec("halt_req", v(1,0,1,0,1,0,1,0));
    cyc_check();
    wr_end();
    idle_cycles(2);
    hart_halted = 1'b1;
    expect_vec("halted", v(1,0,1,1,0,0,1,0));
    cyc_check();
    wr(1, 0, 1);
    expect_vec("ackhavereset1", v(1,0,1,1,0,0,0,0));
    cyc_check();

    // 2: clear haltreq then resume; hart leaves halt two cycles later
    wr(0, 0, 0);
    expect_vec("clr_haltreq", v(0,0,0,1,0,0,0,0));
    cyc_check();
    wr(0, 1, 0);
    expect_vec("resume_req", v(0,1,0,0,0,0,0,0));
    cyc_check();
    wr_end();
    expect_vec("res_pend_hold", v(0,1,0,0,0,0,0,0));
    cyc_check();
    hart_halted = 1'b0;
    expect_vec("resumeack", v(0,0,0,0,1,1,0,0));
    cyc_check();

    // 3: resumereq together with haltreq is ignored
    hart_halted = 1'b1;
    expect_vec("rehalt", v(0,0,0,1,0,1,0,0));
    cyc_check();
    wr(1, 1, 0);
    expect_vec("ign_resume", v(1,0,1,1,0,1,0,0));
    cyc_check();
    wr_end();
    expect_vec("ign_resume_hold", v(1,0,1,1,0,1,0,0));
    cyc_check();

    // 4: resume timeout with the hart stuck halted
    wr(0, 1, 0);
    expect_vec("to_pend", v(0,1,0,0,0,0,0,0));
    cyc_check();
    wr_end();
    for (int i = 0; i < 7; i++) begin
      expect_vec($sformatf("pend_%0d", i + 1), v(0,1,0,0,0,0,0,0));
      cyc_check();
    end
    expect_vec("timeout", v(0,0,0,1,0,0,0,1));
    cyc_check();
    expect_vec("timeout_hold", v(0,0,0,1,0,0,0,1));
    cyc_check();
    wr(0, 1, 0);
    expect_vec("err_clr", v(0,1,0,0,0,0,0,0));
    cyc_check();

    // 5: hart reset during a pending resume with haltreq set
    wr(1, 0, 0);
    expect_vec("hq_in_pend", v(0,1,1,0,0,0,0,0));
    cyc_check();
    wr_end();
    hart_reset = 1'b1;
    hart_halted = 1'b0;
    expect_vec("hart_reset", v(0,0,1,0,0,0,1,0));
    cyc_check();
    wr(1, 0, 1);
    expect_vec("ack_vs_reset", v(0,0,1,0,0,0,1,0));
    cyc_check();
    wr_end();
    hart_reset = 1'b0;
    expect_vec("halt_after_rst", v(1,0,1,0,1,0,1,0));
    cyc_check();
    wr(1, 0, 1);
    expect_vec("ackhavereset2", v(1,0,1,0,1,0,0,0));
    cyc_check();
    wr_end();

    // 6: dmactive soft reset while halted, then asynchronous reset
    hart_halted = 1'b1;
    expect_vec("halted2", v(1,0,1,1,0,0,0,0));
    cyc_check();
    dmactive = 1'b0;
    expect_vec("dmactive_low", v(0,0,0,0,1,0,1,0));
    cyc_check();
    dmactive = 1'b1;
    hart_halted = 1'b0;
    expect_vec("dmactive_high", v(0,0,0,0,1,0,1,0));
    cyc_check();
    wr(1, 0, 0);
    expect_vec("pre_async_rst", v(1,0,1,0,1,0,1,0));
    cyc_check();
    wr_end();
    #2;
    rst_n = 1'b0;
    #1;
    expect_vec("async_rst", v(0,0,0,0,1,0,1,0));
    compare_front();
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(1);

    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
